// File: rtl/bitty_exec_ctrl.sv
// rtl/bitty_exec_ctrl.sv - multi-cycle execute controller with 8x16 register file
module bitty_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [15:0]       ir;
    logic [2:0]        sel_q;

    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [1:0]        fmt;
    logic              fmt_legal;
    logic [DATA_W-1:0] imm_ext;

    assign rx        = ir[15:13];
    assign ry        = ir[12:10];
    assign fmt       = ir[1:0];
    assign fmt_legal = (fmt == 2'b00) || (fmt == 2'b01);
    assign imm_ext   = {{(DATA_W-8){1'b0}}, ir[12:5]};

    // Operands are only reloaded in FETCH, so they naturally hold outside EXEC.
    assign alu_a    = s;
    assign alu_b    = b;
    assign alu_sel  = sel_q;
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = EXEC;
            EXEC:  state_nxt = WB;
            WB: begin
                // A reset landing on the WB cycle suppresses the completion strobe.
                done      = ~reset;
                err       = ~reset & ~fmt_legal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            s     <= '0;
            b     <= '0;
            c     <= '0;
            ir    <= '0;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        ir <= instr;
                    end
                end
                FETCH: begin
                    s     <= regs[rx];
                    b     <= (fmt == 2'b00) ? regs[ry] : imm_ext;
                    sel_q <= ir[4:2];
                end
                EXEC: begin
                    c <= alu_result;
                end
                WB: begin
                    if (fmt_legal) begin
                        regs[rx] <= c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// tb/tb_bitty_exec_ctrl.sv - scoreboard bench for bitty_exec_ctrl with behavioural ALU and register model
module tb_bitty_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_result;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    bitty_exec_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .instr     (instr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_result(alu_result),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b;
            3'd6:    return a >> b;
            default: return (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  sel;
        logic        err;
        logic [2:0]  rx;
        logic [15:0] oldv;
        logic [15:0] newv;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] m_regs [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        stim_own;
    logic [2:0]  stim_addr;
    logic [2:0]  mon_addr;
    assign dbg_addr = stim_own ? stim_addr : mon_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done strobe consumes exactly one expected entry.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending instruction");
            end else begin
                mon_e = q.pop_front();
                chk("alu_a", alu_a, mon_e.a);
                chk("alu_b", alu_b, mon_e.b);
                chk("alu_sel", alu_sel, mon_e.sel);
                chk("err", err, mon_e.err);
                mon_addr = mon_e.rx;
                #1;
                chk("dbg_old_in_wb", dbg_data, mon_e.oldv);
                @(negedge clk);
                #1;
                chk("dbg_new", dbg_data, mon_e.newv);
            end
        end
    end

    task automatic issue(input logic [15:0] ins, input bit noise);
        int          t = 0;
        exp_t        e;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] bv;
        logic [15:0] r;
        @(negedge clk);
        while (busy && t < 20) begin
            if (noise) begin
                run   = 1'($urandom_range(0, 1));
                instr = 16'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_wait: got busy=1 required 0 within 20 cycles");
        end
        rx     = ins[15:13];
        ry     = ins[12:10];
        bv     = (ins[1:0] == 2'b00) ? m_regs[ry] : {8'h00, ins[12:5]};
        r      = alu_f(m_regs[rx], bv, ins[4:2]);
        e.a    = m_regs[rx];
        e.b    = bv;
        e.sel  = ins[4:2];
        e.err  = ins[1];
        e.rx   = rx;
        e.oldv = m_regs[rx];
        e.newv = ins[1] ? m_regs[rx] : r;
        if (!ins[1]) m_regs[rx] = r;
        q.push_back(e);
        run   = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        run   = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 required 0 within 20 cycles");
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, input logic [15:0] req, input string name);
        repeat (2) @(negedge clk);
        stim_own  = 1'b1;
        stim_addr = idx;
        #1;
        chk(name, dbg_data, req);
        stim_own  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          done_at;
        logic [15:0] ins;
        reset     = 1'b1;
        run       = 1'b0;
        instr     = 16'h0000;
        stim_own  = 1'b0;
        stim_addr = 3'd0;
        mon_addr  = 3'd0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) read_reg(3'(i), 16'h0000, "rst_reg");

        // R1 += #5: three busy cycles, done on the third
        issue(16'h20A1, 1'b0);
        cnt     = 0;
        done_at = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (done) done_at = cnt;
        end
        chk("busy_cycles", cnt, 3);
        chk("done_cycle", done_at, 3);

        issue(16'h4061, 1'b0);
        issue(16'h2804, 1'b0);
        @(posedge clk);
        #1;
        chk("exec_alu_a", alu_a, 16'h0005);
        chk("exec_alu_b", alu_b, 16'h0003);
        chk("exec_alu_sel", alu_sel, 3'b001);
        issue(16'h281C, 1'b0);
        @(posedge clk);
        #1;
        chk("cmp_alu_sel", alu_sel, 3'b111);
        issue(16'h2802, 1'b0);
        wait_idle();
        read_reg(3'd1, 16'h0002, "r1_after_illegal");
        read_reg(3'd2, 16'h0003, "r2_value");

        // Run pulse during FETCH must be dropped
        issue(16'h20A1, 1'b0);
        @(negedge clk);
        run   = 1'b1;
        instr = 16'h20A1;
        @(posedge clk);
        #1;
        run   = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        read_reg(3'd1, 16'h0007, "r1_after_ignored_run");
        chk("queue_after_ignored_run", q.size(), 0);

        // Reset on the WB cycle drops the write and the done strobe
        issue(16'h20A1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("wb_reset_done", done, 0);
        chk("wb_reset_err", err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("wb_reset_busy", busy, 0);
        chk("wb_reset_alu_a", alu_a, 0);
        q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        for (int i = 0; i < 8; i++) read_reg(3'(i), 16'h0000, "wb_reset_reg");

        // Random instructions with run/instr noise while busy
        for (int n = 0; n < 250; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ins[1] = 1'b1;
            else ins[1] = 1'b0;
            issue(ins, 1'b1);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        for (int i = 0; i < 8; i++) read_reg(3'(i), m_regs[i], "final_reg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitty_exec_ctrl.md
Name: bitty_exec_ctrl

Overview:
- Multi-cycle execute controller with an 8x16 register file. It sits directly upstream of the bitty ALU and also consumes the ALU result.
- Accepts one 16-bit instruction per run pulse, drives ALU operands and select, then writes the ALU result back to the destination register.
- Exposes busy/done/err status and a debug read port for the bench and top level.

Parameters:
- DATA_W, 16, datapath and register width.
- NREGS, 8, register file depth; index is 3 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start request, sampled only in IDLE.
- instr  input  16  instruction, sampled on the edge that accepts run.
- alu_a  output  16  ALU operand A.
- alu_b  output  16  ALU operand B.
- alu_sel  output  3  ALU select.
- alu_result  input  16  combinational ALU output.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion strobe.
- err  output  1  high during done cycle when the instruction was illegal.
- dbg_addr  input  3  debug register index.
- dbg_data  output  16  combinational read of R[dbg_addr].

Behaviour:
- One clock, clk. Reset is synchronous and active-high; reset is port name reset.
- Reset state: state=IDLE, R0..R7=0, internal regs s/c/ir=0, alu_a=alu_b=0, alu_sel=0, busy=done=err=0.
- Instruction fields:
  - Rx=[15:13], destination and operand A.
  - Ry=[12:10], register operand B.
  - imm=[12:5], 8 bits, zero-extended to 16.
  - sel=[4:2].
  - fmt=[1:0]: 00=register, 01=immediate, 10/11=illegal.
- States: IDLE, FETCH, EXEC, WB.
- IDLE:
  - run=1 at an edge latches ir<=instr and moves to FETCH.
  - run=0 stays in IDLE.
- FETCH:
  - s<=R[ir.Rx].
  - Operand latch: b<=R[ir.Ry] if fmt=00, else zero-extended imm.
  - Next state EXEC.
- EXEC:
  - alu_a=s, alu_b=b, alu_sel=ir.sel, driven from registered values.
  - c<=alu_result at the edge.
  - Next state WB.
- WB:
  - done=1 for exactly this cycle.
  - If fmt is legal: R[ir.Rx]<=c at the end of the cycle, err=0.
  - If fmt is illegal: no write, err=1.
  - Next state IDLE.
- Outside EXEC, alu_a/alu_b/alu_sel hold their last values. They are don't-care for the ALU but must be stable, with no X.
- Latency: run accepted at edge k gives FETCH in cycle k+1, EXEC in k+2, and WB/done in k+3. The new register value is visible on dbg_data from cycle k+4. Back-to-back run can be accepted at edge k+4.
- run while busy is ignored and not queued. instr changes while busy have no effect.
- Compare results (sel=111, values 0/1/2) are written back like any other result.
- Shift amounts use the full 16-bit b. Add/sub wrap modulo 2^16.
- Rx=Ry reads the same register for both operands.
- Reset asserted in any state returns to IDLE next cycle and clears all registers. A write pending in WB is dropped and done is forced to 0.
- dbg_data is purely combinational. A read of the register being written in WB returns the old value.

Test Plan:
- Reset, then run with 0x20A1 (R1 += #5) → busy high for 3 cycles, done in the 3rd cycle after acceptance, err=0, R1=0x0005.
- Run 0x4061 (R2 += #3), then 0x2804 (R1 -= R2, register format) → during EXEC alu_a=5, alu_b=3, alu_sel=001; R1=0x0002.
- Run 0x281C (compare R1=2 vs R2=3) → alu_sel=111; R1=0x0002 (less-than code).
- Run 0x2802 (fmt=10) → done=1, err=1, R1 unchanged at 0x0002.
- Pulse run with 0x20A1 during FETCH of another instruction → second request ignored, exactly one done, R1 reflects only the first instruction.
- Assert reset during WB of 0x20A1 → done=0 that cycle, state IDLE, all R*=0, busy=0.
